mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the CHARIS-style 32-bit datapath. It is the successor of the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states and waits on ready handshakes from instruction and data memory. Instruction width, ALU function width and memory timeout are parametrised. A stalled memory access or an illegal opcode drives the unit into a sticky error state.

## Interface
- INSTR_W, 32, instruction width; opcode is always Instr[INSTR_W-1 -: 6], funct is Instr[5:0]
- FUNC_W, 4, ALU_func width (≥4)
- MEM_TIMEOUT, 16, maximum wait cycles for IMem_Rdy/DMem_Rdy (≥1)

- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- Instr  in  INSTR_W  instruction-register contents (IR loaded by IR_LdEn)
- Zero  in  1  ALU zero flag
- IMem_Rdy, DMem_Rdy  in  1  memory ready handshakes
- PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel  out  1  datapath controls (PC_sel 1 = branch target; RF_WrData_sel 1 = memory data)
- ALU_func  out  FUNC_W  ALU operation
- Mem_RdEn, Mem_WrEn, lui, lb, sb  out  1  memory/immediate controls
- Err  out  1  sticky error flag
- State  out  3  current state (debug)

## Operation
- States: IF, DEC, EX, MEM, WB, ERR.
- IF: Mem_RdEn=0. Wait for IMem_Rdy. On IMem_Rdy: IR_LdEn=1, PC_LdEn=1, PC_sel=0 (PC+4), then go to DEC.
- DEC: read RF. RF_B_sel=1 for I-type/store/branch. If the opcode is not in the decoded set, go to ERR. Otherwise go to EX.
- EX, R-type (opcode 100000): ALU_func=funct[3:0] (add 0000, sub 0001, and 0010, or 0011, not 0100, sra 1000, sll 1001, srl 1010, rol 1100, ror 1101). Any other funct goes to ERR.
- EX, immediates: li 111000, lui 111001, addi 110000 → add. andi 110010 → and. ori 110011 → or. ALU_Bin_sel=1. lui=1 for lui.
- EX, branches: b 111111 always taken. beq 000000 taken if Zero=1. bne 000001 taken if Zero=0. When taken, PC_LdEn=1 and PC_sel=1. Next state is IF. The all-zero nop decodes as beq r0,r0,0 and is harmless.
- EX, memory: lb 000011, lw 001111, sb 000111, sw 011111. ALU_Bin_sel=1, ALU_func=add. Next state is MEM.
- MEM: Mem_RdEn=1 for loads. Mem_WrEn=1 for stores, held until DMem_Rdy. lb/sb assert for the whole state. Loads go to WB. Stores go to IF.
- WB: RF_WrEn=1 for one cycle. RF_WrData_sel=1 for loads. Next state is IF.
- Timeout: an internal counter clears on entry to IF or MEM and increments each cycle Rdy is low. When count = MEM_TIMEOUT, go to ERR.
- ERR: all enables are 0 and Err=1 until Reset.

## Timing
- Outputs are combinational from the registered state and Instr. State transitions occur on the rising edge of clk.
- While Reset is high: state=IF, counter=0, every output 0 (Rdy-dependent outputs are gated by Reset), Err=0.
- With zero-wait memory: R/I-type takes 4 cycles, loads 5, stores 4, branches 3.
- Each cycle of low Rdy adds one cycle. Rdy is sampled only in IF/MEM and ignored elsewhere.
- Rdy high in the same cycle the counter reaches MEM_TIMEOUT: Rdy wins, and the unit does not enter ERR.
- Reset mid-instruction aborts immediately. No write enable is asserted after Reset rises.
- PC_LdEn is asserted at most once per instruction, except for taken branches (IF +4, then EX target).

## Structure
- Package mc_ctrl_pkg: opcode and funct localparams, ALU_func codes, state encoding (3-bit), FUNC_W default.
- Sub-module mem_wait_timer: counter with clear, enable and terminal flag, parametrised by MEM_TIMEOUT.
- FSM next-state and output decode live in mc_control_fsm.

## Test plan
- add $r2,$r7,$r6 (0x80463830), Rdy always 1 → States IF,DEC,EX,WB. ALU_func=0000. RF_WrEn high only in cycle 4.
- lw (0x3C230003), DMem_Rdy low for 3 cycles → MEM lasts 4 cycles. Mem_RdEn high throughout. WB has RF_WrData_sel=1. Total 8 cycles.
- beq with Zero=1, then bne with Zero=1 → beq has PC_LdEn=1/PC_sel=1 in EX. bne has PC_LdEn=0 in EX. Both return to IF after 3 cycles.
- sb (0x1C230003) → sb=1 and Mem_WrEn=1 in MEM. RF_WrEn is never set. Next state is IF.
- IMem_Rdy held low with MEM_TIMEOUT=16 → ERR after 16 wait cycles. Err=1 sticky. A Reset pulse returns to IF with all outputs 0.
- Opcode 010101, and R-type funct 111111 → ERR from DEC/EX. No RF_WrEn or Mem_WrEn is ever asserted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU codes, states
// and the opcode classifier used by the FSM.
package mc_ctrl_pkg;

  localparam int FUNC_W_DEF = 4;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_ROL = 4'b1100;
  localparam logic [3:0] ALU_ROR = 4'b1101;

  // IF is encoded as zero so the debug State port reads 0 while in reset.
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DEC = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IMM, C_BR, C_LOAD, C_STORE, C_BAD
  } op_class_t;

  function automatic op_class_t classify(input logic [5:0] op);
    case (op)
      OP_RTYPE:                              return C_R;
      OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: return C_IMM;
      OP_B, OP_BEQ, OP_BNE:                  return C_BR;
      OP_LB, OP_LW:                          return C_LOAD;
      OP_SB, OP_SW:                          return C_STORE;
      default:                               return C_BAD;
    endcase
  endfunction

  function automatic logic funct_ok(input logic [3:0] f);
    case (f)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT,
      ALU_SRA, ALU_SLL, ALU_SRL, ALU_ROL, ALU_ROR: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; done flags that the count
// has reached MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count;

  assign done = (count == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en && !done)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences IF/DEC/EX/MEM/WB with memory ready
// handshakes, a wait timeout and a sticky error state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 32,
  parameter int FUNC_W      = FUNC_W_DEF,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Zero,
  input  logic               IMem_Rdy,
  input  logic               DMem_Rdy,
  output logic               PC_sel,
  output logic               PC_LdEn,
  output logic               IR_LdEn,
  output logic               RF_WrEn,
  output logic               RF_WrData_sel,
  output logic               RF_B_sel,
  output logic               ALU_Bin_sel,
  output logic [FUNC_W-1:0]  ALU_func,
  output logic               Mem_RdEn,
  output logic               Mem_WrEn,
  output logic               lui,
  output logic               lb,
  output logic               sb,
  output logic               Err,
  output logic [2:0]         State
);

  state_t    state, state_next;
  op_class_t cls;
  logic [5:0] opcode;
  logic [3:0] funct;
  logic       waiting, rdy, tmo, tmr_clear, taken;
  logic [3:0] func_code;
  logic       unused_instr;

  assign opcode       = Instr[INSTR_W-1 -: 6];
  assign funct        = Instr[3:0];
  assign unused_instr = ^Instr[INSTR_W-7:4];
  assign cls          = classify(opcode);
  assign waiting      = (state == S_IF) || (state == S_MEM);
  assign rdy          = (state == S_IF) ? IMem_Rdy : DMem_Rdy;
  assign tmr_clear    = !waiting || (state_next != state);
  assign taken        = (opcode == OP_B) || (opcode == OP_BEQ && Zero) ||
                        (opcode == OP_BNE && !Zero);
  assign State        = state;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk   (clk),
    .rst   (Reset),
    .clear (tmr_clear),
    .en    (waiting && !rdy),
    .done  (tmo)
  );

  // Rdy is checked before the timeout so a late handshake still completes.
  always_comb begin
    state_next = state;
    case (state)
      S_IF:  if (IMem_Rdy) state_next = S_DEC;
             else if (tmo) state_next = S_ERR;
      S_DEC: state_next = (cls == C_BAD) ? S_ERR : S_EX;
      S_EX: begin
        case (cls)
          C_R:              state_next = funct_ok(funct) ? S_WB : S_ERR;
          C_IMM:            state_next = S_WB;
          C_BR:             state_next = S_IF;
          C_LOAD, C_STORE:  state_next = S_MEM;
          default:          state_next = S_ERR;
        endcase
      end
      S_MEM: if (DMem_Rdy) state_next = (cls == C_LOAD) ? S_WB : S_IF;
             else if (tmo) state_next = S_ERR;
      S_WB:  state_next = S_IF;
      default: state_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      state <= S_IF;
    else
      state <= state_next;
  end

  always_comb begin
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    Mem_RdEn      = 1'b0;
    Mem_WrEn      = 1'b0;
    lui           = 1'b0;
    lb            = 1'b0;
    sb            = 1'b0;
    Err           = 1'b0;
    func_code     = ALU_ADD;
    if (!Reset) begin
      case (state)
        S_IF: begin
          IR_LdEn = IMem_Rdy;
          PC_LdEn = IMem_Rdy;
        end
        S_DEC: RF_B_sel = (cls != C_R) && (cls != C_BAD);
        S_EX: begin
          case (cls)
            C_R: if (funct_ok(funct)) func_code = funct;
            C_IMM: begin
              ALU_Bin_sel = 1'b1;
              lui         = (opcode == OP_LUI);
              if (opcode == OP_ANDI)     func_code = ALU_AND;
              else if (opcode == OP_ORI) func_code = ALU_OR;
            end
            // Branches compare through subtraction to produce Zero.
            C_BR: begin
              func_code = ALU_SUB;
              PC_LdEn   = taken;
              PC_sel    = taken;
            end
            C_LOAD, C_STORE: ALU_Bin_sel = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          Mem_RdEn = (cls == C_LOAD);
          Mem_WrEn = (cls == C_STORE);
          lb       = (opcode == OP_LB);
          sb       = (opcode == OP_SB);
        end
        S_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = (cls == C_LOAD);
        end
        S_ERR: Err = 1'b1;
        default: ;
      endcase
    end
    ALU_func = FUNC_W'(func_code);
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: driver pushes the expected per-cycle
// output vector, a negedge monitor pops and compares.
module tb_mc_control_fsm;

  localparam int W = 20;

  localparam logic [2:0] T_IF = 3'd0, T_DEC = 3'd1, T_EX = 3'd2, T_MEM = 3'd3,
                         T_WB = 3'd4, T_ERR = 3'd5;

  // Output vector: {State, Err, PC_sel, PC_LdEn, IR_LdEn, RF_WrEn,
  // RF_WrData_sel, RF_B_sel, ALU_Bin_sel, Mem_RdEn, Mem_WrEn, lui, lb, sb, ALU_func}
  localparam logic [W-1:0] ERR = 20'h10000, PCS = 20'h08000, PCL = 20'h04000,
                           IRL = 20'h02000, RFW = 20'h01000, WDS = 20'h00800,
                           BSL = 20'h00400, BIN = 20'h00200, MRD = 20'h00100,
                           MWR = 20'h00080, LUI = 20'h00040, LBF = 20'h00020,
                           SBF = 20'h00010;

  logic clk = 1'b1;
  logic Reset, Zero, IMem_Rdy, DMem_Rdy;
  logic [31:0] Instr;
  logic PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic Mem_RdEn, Mem_WrEn, lui, lb, sb, Err;
  logic [3:0] ALU_func;
  logic [2:0] State;

  logic [W-1:0] exp_q[$];
  int tag_q[$];
  int n_pass = 0, n_total = 0, tag = 0;
  logic [W-1:0] exp_v, act;
  int exp_t;

  always #5 clk = ~clk;

  mc_control_fsm #(.INSTR_W(32), .FUNC_W(4), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .IMem_Rdy(IMem_Rdy), .DMem_Rdy(DMem_Rdy),
    .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .Mem_RdEn(Mem_RdEn), .Mem_WrEn(Mem_WrEn),
    .lui(lui), .lb(lb), .sb(sb), .Err(Err), .State(State)
  );

  function automatic logic [W-1:0] s(input logic [2:0] st);
    return {st, 17'd0};
  endfunction

  // Monitor: one expected vector per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      exp_t = tag_q.pop_front();
      act = {State, Err, PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel,
             RF_B_sel, ALU_Bin_sel, Mem_RdEn, Mem_WrEn, lui, lb, sb, ALU_func};
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL vec tag=%0d got=%h exp=%h", exp_t, act, exp_v);
    end
  end

  task automatic step(input logic [31:0] ins, input logic z, input logic ir,
                      input logic dr, input logic rst, input logic [W-1:0] e);
    Instr = ins; Zero = z; IMem_Rdy = ir; DMem_Rdy = dr; Reset = rst;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tag++;
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, s(T_IF));
    step(32'h0, 1'b0, 1'b1, 1'b1, 1'b1, s(T_IF));
  endtask

  task automatic fetch(input logic [31:0] ins, input logic dec_b);
    tag++;
    step(ins, 1'b0, 1'b1, 1'b1, 1'b0, s(T_IF) | IRL | PCL);
    step(ins, 1'b0, 1'b1, 1'b1, 1'b0, s(T_DEC) | (dec_b ? BSL : '0));
  endtask

  task automatic alu_instr(input logic [31:0] ins, input logic dec_b,
                           input logic [W-1:0] ex_e);
    fetch(ins, dec_b);
    step(ins, 1'b0, 1'b1, 1'b1, 1'b0, s(T_EX) | ex_e);
    step(ins, 1'b0, 1'b1, 1'b1, 1'b0, s(T_WB) | RFW);
  endtask

  task automatic branch(input logic [31:0] ins, input logic z,
                        input logic [W-1:0] ex_e);
    fetch(ins, 1'b1);
    step(ins, z, 1'b1, 1'b1, 1'b0, s(T_EX) | ex_e);
  endtask

  task automatic mem_instr(input logic [31:0] ins, input int waits,
                           input logic [W-1:0] mem_e, input logic is_load);
    fetch(ins, 1'b1);
    step(ins, 1'b0, 1'b1, 1'b1, 1'b0, s(T_EX) | BIN);
    for (int i = 0; i < waits; i++)
      step(ins, 1'b0, 1'b1, 1'b0, 1'b0, s(T_MEM) | mem_e);
    step(ins, 1'b0, 1'b1, 1'b1, 1'b0, s(T_MEM) | mem_e);
    if (is_load) step(ins, 1'b0, 1'b1, 1'b1, 1'b0, s(T_WB) | RFW | WDS);
  endtask

  initial begin
    do_reset();
    alu_instr(32'h80463830, 1'b0, 20'h0);                 // add
    mem_instr(32'h3C230003, 3, MRD, 1'b1);                // lw, 3 wait cycles
    branch(32'h00000000, 1'b1, PCL | PCS | 20'h1);        // beq taken
    branch(32'h04000000, 1'b1, 20'h1);                    // bne not taken
    branch(32'h04000000, 1'b0, PCL | PCS | 20'h1);        // bne taken
    branch(32'hFC000000, 1'b0, PCL | PCS | 20'h1);        // b
    mem_instr(32'h1C230003, 0, MWR | SBF, 1'b0);          // sb
    mem_instr(32'h7C000000, 1, MWR, 1'b0);                // sw, 1 wait
    alu_instr(32'hC0000005, 1'b1, BIN);                   // addi
    alu_instr(32'hE4000005, 1'b1, BIN | LUI);             // lui
    alu_instr(32'hC8000000, 1'b1, BIN | 20'h2);           // andi
    alu_instr(32'hCC000000, 1'b1, BIN | 20'h3);           // ori
    alu_instr(32'h80000008, 1'b0, 20'h8);                 // sra
    mem_instr(32'h0C000000, 0, MRD | LBF, 1'b1);          // lb

    // Instruction fetch stalls two cycles, then a nop runs.
    tag++;
    step(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, s(T_IF));
    step(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, s(T_IF));
    branch(32'h00000000, 1'b1, PCL | PCS | 20'h1);

    // Reset in the middle of a stalled load aborts it.
    fetch(32'h3C230003, 1'b1);
    step(32'h3C230003, 1'b0, 1'b1, 1'b1, 1'b0, s(T_EX) | BIN);
    step(32'h3C230003, 1'b0, 1'b1, 1'b0, 1'b0, s(T_MEM) | MRD);
    do_reset();

    // Rdy arrives on the cycle the count hits the limit: no error.
    tag++;
    for (int i = 0; i < 16; i++) step(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, s(T_IF));
    step(32'h0, 1'b1, 1'b1, 1'b1, 1'b0, s(T_IF) | IRL | PCL);
    step(32'h0, 1'b1, 1'b1, 1'b1, 1'b0, s(T_DEC) | BSL);
    step(32'h0, 1'b1, 1'b1, 1'b1, 1'b0, s(T_EX) | PCL | PCS | 20'h1);

    // Fetch never ready: error after the limit, sticky until reset.
    tag++;
    for (int i = 0; i < 17; i++) step(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, s(T_IF));
    for (int i = 0; i < 3; i++) step(32'h0, 1'b1, 1'b1, 1'b1, 1'b0, s(T_ERR) | ERR);
    do_reset();

    // Data memory never ready on a load.
    fetch(32'h3C230003, 1'b1);
    step(32'h3C230003, 1'b0, 1'b1, 1'b1, 1'b0, s(T_EX) | BIN);
    for (int i = 0; i < 17; i++)
      step(32'h3C230003, 1'b0, 1'b1, 1'b0, 1'b0, s(T_MEM) | MRD);
    step(32'h3C230003, 1'b0, 1'b1, 1'b1, 1'b0, s(T_ERR) | ERR);
    do_reset();

    // Illegal opcode errors out of DEC.
    fetch(32'h54000000, 1'b0);
    step(32'h54000000, 1'b0, 1'b1, 1'b1, 1'b0, s(T_ERR) | ERR);
    step(32'h54000000, 1'b0, 1'b1, 1'b1, 1'b0, s(T_ERR) | ERR);
    do_reset();

    // Illegal R-type funct errors out of EX.
    fetch(32'h8000003F, 1'b0);
    step(32'h8000003F, 1'b0, 1'b1, 1'b1, 1'b0, s(T_EX));
    step(32'h8000003F, 1'b0, 1'b1, 1'b1, 1'b0, s(T_ERR) | ERR);
    step(32'h8000003F, 1'b0, 1'b1, 1'b1, 1'b0, s(T_ERR) | ERR);
    do_reset();

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
